// File: rtl/spook_pkg.sv
// spook_pkg: shared types and defaults for the Spook round-unit sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default step/round counts, ru_sel lane encodings.
package spook_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_DBOX  = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int NUM_STEPS_DEF       = 6;
    localparam int ROUNDS_PER_STEP_DEF = 2;

    localparam logic SEL_CLYDE  = 1'b0;
    localparam logic SEL_SHADOW = 1'b1;

endpackage

// File: rtl/lsd_round_sched_if.sv
// lsd_round_sched_if: controller/round-unit control bundle of the LS round scheduler.
// Latency: n/a (wires only).
// Backpressure: none; starts are pulses, dones are one-cycle pulses.
// master = AEAD controller side (drives starts/inv), slave = scheduler side.
interface lsd_round_sched_if;
    logic       start_tls;
    logic       start_perm;
    logic       inv;
    logic       tls_done;
    logic       perm_done;
    logic       busy;
    logic       ru_sel;
    logic       ru_ld;
    logic       ru_en;
    logic       ru_inv;
    logic       dbox_en;
    logic       tk_add;
    logic [2:0] step_idx;
    logic       round_idx;
    logic       req_overrun;

    modport master (
        output start_tls, start_perm, inv,
        input  tls_done, perm_done, busy, ru_sel, ru_ld, ru_en, ru_inv,
               dbox_en, tk_add, step_idx, round_idx, req_overrun
    );

    modport slave (
        input  start_tls, start_perm, inv,
        output tls_done, perm_done, busy, ru_sel, ru_ld, ru_en, ru_inv,
               dbox_en, tk_add, step_idx, round_idx, req_overrun
    );
endinterface

// File: rtl/lsd_req_latch.sv
// lsd_req_latch: one-deep pending flag for a primitive's start request, with duplicate detect.
// Latency: req is combinational from start (same-cycle bypass); flag set on the next edge.
// Backpressure: a start while already pending or active is dropped and reported on overrun.
// Ports: clk/rst, start pulse, active (primitive occupying the round unit), grant, req, overrun.
module lsd_req_latch (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic grant,
    output logic req,
    output logic overrun
);
    logic pend;
    logic accept;

    assign accept  = start & ~pend & ~active;
    assign req     = pend | accept;
    assign overrun = start & (pend | active);

    // A grant consumes either the stored flag or the bypassed start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (grant) begin
            pend <= 1'b0;
        end else if (accept) begin
            pend <= 1'b1;
        end
    end
endmodule

// File: rtl/lsd_round_sched.sv
// lsd_round_sched: sequences the shared LS round unit for Clyde-128 (TBC) and Shadow-512 (permutation).
// Latency: start-in-IDLE to done pulse 20 cycles (Shadow) / 15 (Clyde); 14 / 9 with UNROLL2_EN.
// Backpressure: none; one pending request per primitive, duplicates dropped and flagged in sticky req_overrun.
// Ports: clk, rst (async active-high), bus (slave): start_tls/start_perm/inv in; tls_done/perm_done,
//        busy, ru_sel/ru_ld/ru_en/ru_inv/dbox_en/tk_add, step_idx/round_idx, req_overrun out.
// Build option: UNROLL2_EN -- round unit does both rounds of a step per ru_en, round_idx tied 0.
module lsd_round_sched
    import spook_pkg::*;
#(
    parameter int NUM_STEPS       = NUM_STEPS_DEF,
    parameter int ROUNDS_PER_STEP = ROUNDS_PER_STEP_DEF
) (
    input logic               clk,
    input logic               rst,
    lsd_round_sched_if.slave  bus
);

    generate
        if (NUM_STEPS < 1 || NUM_STEPS > 8) begin : g_bad_steps
            $error("lsd_round_sched: NUM_STEPS must be 1..8 (3-bit step_idx)");
        end
`ifdef UNROLL2_EN
        if (ROUNDS_PER_STEP != 2) begin : g_bad_rps
            $error("lsd_round_sched: ROUNDS_PER_STEP must be 2 when unrolled");
        end
`else
        if (ROUNDS_PER_STEP < 1 || ROUNDS_PER_STEP > 2) begin : g_bad_rps
            $error("lsd_round_sched: ROUNDS_PER_STEP must be 1..2 (1-bit round_idx)");
        end
`endif
    endgenerate

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    state_t     state, state_nxt;
    logic       sel_q, inv_q, ovr_q;
    logic [2:0] step_q;
    logic       rnd_q;
    logic       req_perm, req_tls, ovr_perm, ovr_tls;
    logic       grant_win, grant_perm, grant_tls;
    logic       busy_c, clyde, last_round, last_step;

    assign busy_c    = (state == ST_LOAD) || (state == ST_ROUND) ||
                       (state == ST_DBOX) || (state == ST_FINAL);
    assign clyde     = (sel_q == SEL_CLYDE);
    // DONE arbitrates like IDLE so a queued request loads straight after the done pulse.
    assign grant_win  = (state == ST_IDLE) || (state == ST_DONE);
    assign grant_perm = grant_win & req_perm;
    assign grant_tls  = grant_win & req_tls & ~req_perm;
    // inv_q is 0 for Shadow, so Shadow always walks forward.
    assign last_step  = inv_q ? (step_q == 3'd0) : (step_q == LAST_STEP);

    lsd_req_latch u_perm_latch (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.start_perm),
        .active  (busy_c & (sel_q == SEL_SHADOW)),
        .grant   (grant_perm),
        .req     (req_perm),
        .overrun (ovr_perm)
    );

    lsd_req_latch u_tls_latch (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.start_tls),
        .active  (busy_c & clyde),
        .grant   (grant_tls),
        .req     (req_tls),
        .overrun (ovr_tls)
    );

`ifdef UNROLL2_EN
    assign last_round = 1'b1;
    assign rnd_q      = 1'b0;
`else
    localparam logic LAST_RND = 1'(ROUNDS_PER_STEP - 1);

    assign last_round = inv_q ? (rnd_q == 1'b0) : (rnd_q == LAST_RND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q <= 1'b0;
        end else if (grant_perm) begin
            rnd_q <= 1'b0;
        end else if (grant_tls) begin
            rnd_q <= bus.inv ? LAST_RND : 1'b0;
        end else if (state == ST_ROUND) begin
            if (!last_round) begin
                rnd_q <= inv_q ? (rnd_q - 1'b1) : (rnd_q + 1'b1);
            end else if (clyde) begin
                rnd_q <= inv_q ? LAST_RND : 1'b0;
            end
        end else if (state == ST_DBOX) begin
            rnd_q <= 1'b0;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = (grant_perm | grant_tls) ? ST_LOAD : ST_IDLE;
            ST_LOAD:          state_nxt = ST_ROUND;
            ST_ROUND: begin
                if (last_round) begin
                    if (!clyde) begin
                        state_nxt = ST_DBOX;
                    end else if (last_step) begin
                        state_nxt = ST_FINAL;
                    end
                end
            end
            ST_DBOX:          state_nxt = last_step ? ST_DONE : ST_ROUND;
            ST_FINAL:         state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Grant-time context and step counter; sel/inv stay frozen until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= SEL_CLYDE;
            inv_q  <= 1'b0;
            step_q <= 3'd0;
            ovr_q  <= 1'b0;
        end else begin
            ovr_q <= ovr_q | ovr_perm | ovr_tls;
            if (grant_perm) begin
                sel_q  <= SEL_SHADOW;
                inv_q  <= 1'b0;
                step_q <= 3'd0;
            end else if (grant_tls) begin
                sel_q  <= SEL_CLYDE;
                inv_q  <= bus.inv;
                step_q <= bus.inv ? LAST_STEP : 3'd0;
            end else if (state == ST_ROUND && last_round && clyde) begin
                step_q <= inv_q ? (step_q - 3'd1) : (step_q + 3'd1);
            end else if (state == ST_DBOX) begin
                step_q <= step_q + 3'd1;
            end
        end
    end

    // Output logic
    always_comb begin
        bus.busy        = busy_c;
        bus.ru_ld       = (state == ST_LOAD);
        bus.ru_en       = (state == ST_ROUND);
        bus.dbox_en     = (state == ST_DBOX);
        // Clyde adds the tweakey at load and after every step's last round.
        bus.tk_add      = clyde & ((state == ST_LOAD) || (state == ST_ROUND && last_round));
        bus.tls_done    = (state == ST_DONE) & clyde;
        bus.perm_done   = (state == ST_DONE) & ~clyde;
        bus.ru_sel      = (state != ST_IDLE) & sel_q;
        bus.ru_inv      = (state != ST_IDLE) & inv_q;
        bus.step_idx    = step_q;
        bus.round_idx   = rnd_q;
        bus.req_overrun = ovr_q;
    end

endmodule

// File: tb/tb_lsd_round_sched.sv
module tb_lsd_round_sched;

`ifdef UNROLL2_EN
    localparam int RPS_EFF  = 1;
    localparam int LAT_PERM = 14;
    localparam int LAT_TLS  = 9;
`else
    localparam int RPS_EFF  = 2;
    localparam int LAT_PERM = 20;
    localparam int LAT_TLS  = 15;
`endif
    localparam int NSTEP = 6;

    logic clk = 1'b0;
    logic rst;

    lsd_round_sched_if bus ();

    lsd_round_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_perm;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    int         n_en = 0, n_dbox = 0, n_tk = 0;
    logic [3:0] en_tr[$];
    logic [2:0] dbox_tr[$];
    int         ld_cyc = -1;
    logic       ld_sel = 1'b0, ld_inv = 1'b0, ld_tk = 1'b0;

    // Monitor: samples on the falling edge, logs outputs and done events.
    always @(negedge clk) begin
        ev_t ev;
        if (bus.ru_en) begin
            n_en++;
            en_tr.push_back({bus.step_idx, bus.round_idx});
        end
        if (bus.dbox_en) begin
            n_dbox++;
            dbox_tr.push_back(bus.step_idx);
        end
        if (bus.tk_add) n_tk++;
        if (bus.ru_ld) begin
            ld_cyc = cyc;
            ld_sel = bus.ru_sel;
            ld_inv = bus.ru_inv;
            ld_tk  = bus.tk_add;
        end
        if (bus.perm_done) begin
            ev.is_perm = 1'b1;
            ev.cyc = cyc;
            obs_q.push_back(ev);
        end
        if (bus.tls_done) begin
            ev.is_perm = 1'b0;
            ev.cyc = cyc;
            obs_q.push_back(ev);
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit t, input bit p, input bit iv);
        bus.start_tls  = t;
        bus.start_perm = p;
        bus.inv        = iv;
        tick();
        bus.start_tls  = 1'b0;
        bus.start_perm = 1'b0;
    endtask

    task automatic push_exp(input bit is_perm, input int c);
        ev_t e;
        e.is_perm = is_perm;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Scoreboard: wait (bounded) for the next observed done and compare with the oldest expectation.
    task automatic sb_pop(input string name);
        ev_t e, o;
        int  n = 0;
        while (obs_q.size() == 0 && n < 100) begin
            tick();
            n++;
        end
        check({name, " done seen"}, int'(obs_q.size() != 0), 1);
        if (obs_q.size() != 0 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({name, " kind"}, int'(o.is_perm), int'(e.is_perm));
            check({name, " cycle"}, o.cyc, e.cyc);
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end
    endtask

    function automatic logic [13:0] pack_outs();
        return {bus.busy, bus.ru_sel, bus.ru_ld, bus.ru_en, bus.ru_inv, bus.dbox_en,
                bus.tk_add, bus.step_idx, bus.round_idx, bus.req_overrun,
                bus.tls_done, bus.perm_done};
    endfunction

    typedef struct {
        bit tls;
        bit perm;
        bit iv;
        bit exp_perm;
        int lat;
        int en;
        int dbox;
        int tk;
        bit sel;
        bit rinv;
    } vec_t;

    vec_t vt[4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int         t0, b_en, b_db, b_tk, b_tr, b_dt, bad, s, r;
        logic [3:0] expv;

        vt[0] = '{1'b0, 1'b1, 1'b0, 1'b1, LAT_PERM, NSTEP * RPS_EFF, NSTEP, 0,         1'b1, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, LAT_PERM, NSTEP * RPS_EFF, NSTEP, 0,         1'b1, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, LAT_TLS,  NSTEP * RPS_EFF, 0,     NSTEP + 1, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, LAT_TLS,  NSTEP * RPS_EFF, 0,     NSTEP + 1, 1'b0, 1'b1};

        rst            = 1'b1;
        bus.start_tls  = 1'b0;
        bus.start_perm = 1'b0;
        bus.inv        = 1'b0;
        repeat (3) tick();
        check("reset outputs", int'(pack_outs()), 0);
        rst = 1'b0;
        repeat (2) tick();
        check("idle after reset busy", int'(bus.busy), 0);

        // Table-driven single operations
        for (int i = 0; i < 4; i++) begin
            b_en = n_en;
            b_db = n_dbox;
            b_tk = n_tk;
            b_tr = en_tr.size();
            b_dt = dbox_tr.size();
            t0   = cyc;
            push_exp(vt[i].exp_perm, t0 + vt[i].lat);
            pulse(vt[i].tls, vt[i].perm, vt[i].iv);
            bus.inv = ~vt[i].iv;   // must be ignored mid-operation
            sb_pop($sformatf("vec%0d", i));
            repeat (2) tick();
            check($sformatf("vec%0d ru_en count", i), n_en - b_en, vt[i].en);
            check($sformatf("vec%0d dbox count", i), n_dbox - b_db, vt[i].dbox);
            check($sformatf("vec%0d tk_add count", i), n_tk - b_tk, vt[i].tk);
            check($sformatf("vec%0d load cycle", i), ld_cyc, t0 + 1);
            check($sformatf("vec%0d load sel", i), int'(ld_sel), int'(vt[i].sel));
            check($sformatf("vec%0d load inv", i), int'(ld_inv), int'(vt[i].rinv));
            check($sformatf("vec%0d load tk_add", i), int'(ld_tk), int'(vt[i].tls));
            bad = 0;
            for (int k = 0; k < vt[i].en; k++) begin
                s = k / RPS_EFF;
                r = k % RPS_EFF;
                if (vt[i].tls && vt[i].iv) begin
                    s = NSTEP - 1 - s;
                    r = RPS_EFF - 1 - r;
                end
                expv = {s[2:0], r[0]};
                if (b_tr + k >= en_tr.size() || en_tr[b_tr + k] != expv) bad++;
            end
            check($sformatf("vec%0d step/round trace errors", i), bad, 0);
            bad = 0;
            for (int k = 0; k < vt[i].dbox; k++) begin
                if (b_dt + k >= dbox_tr.size() || int'(dbox_tr[b_dt + k]) != k) bad++;
            end
            check($sformatf("vec%0d dbox step errors", i), bad, 0);
        end

        // Same-cycle dual start: Shadow first, Clyde loads right after perm_done
        t0 = cyc;
        push_exp(1'b1, t0 + LAT_PERM);
        push_exp(1'b0, t0 + LAT_PERM + LAT_TLS);
        pulse(1'b1, 1'b1, 1'b0);
        sb_pop("dual perm");
        sb_pop("dual tls");
        check("dual tls load cycle", ld_cyc, t0 + LAT_PERM + 1);
        check("dual tls load sel", int'(ld_sel), 0);
        repeat (2) tick();

        // Duplicate Shadow start while Shadow is active
        check("overrun clear before", int'(bus.req_overrun), 0);
        t0 = cyc;
        push_exp(1'b1, t0 + LAT_PERM);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (4) tick();
        pulse(1'b0, 1'b1, 1'b0);
        tick();
        check("overrun set", int'(bus.req_overrun), 1);
        sb_pop("overrun perm");
        repeat (40) tick();
        check("overrun single done", obs_q.size(), 0);
        check("overrun sticky", int'(bus.req_overrun), 1);

        // Reset in the middle of an inverse Clyde run
        t0 = cyc;
        pulse(1'b1, 1'b0, 1'b1);
        while (cyc < t0 + 8) tick();
        check("abort run busy", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("abort outputs", int'(pack_outs()), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (30) tick();
        check("abort no done", obs_q.size(), 0);
        t0 = cyc;
        push_exp(1'b0, t0 + LAT_TLS);
        pulse(1'b1, 1'b0, 1'b0);
        sb_pop("post-reset tls");
        repeat (3) tick();

        check("expectations left", exp_q.size(), 0);
        check("unexpected dones left", obs_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
